// File: rtl/ddrphy_dll_update_ctrl_if.sv
// ---------------------------------------------------------------------------
// ddrphy_dll_update_ctrl_if
//   Handshake bundle between the DDR PHY reset controller and the DLL update
//   controller.
//
//   Signals:
//     dll_update_req_rst_ctrl  reset ctrl -> dll ctrl  DLL update request
//     dll_update_ack_rst_ctrl  dll ctrl -> reset ctrl  DLL update acknowledge
//     dll_update_iorst_req     dll ctrl -> reset ctrl  IO-reset request
//     dll_update_iorst_ack     reset ctrl -> dll ctrl  IO-reset acknowledge
//
//   Modports:
//     master  reset-controller side
//     slave   DLL update controller side
// ---------------------------------------------------------------------------
`default_nettype none

interface ddrphy_dll_update_ctrl_if;
  logic dll_update_req_rst_ctrl;
  logic dll_update_ack_rst_ctrl;
  logic dll_update_iorst_req;
  logic dll_update_iorst_ack;

  modport master (
    output dll_update_req_rst_ctrl,
    input  dll_update_ack_rst_ctrl,
    input  dll_update_iorst_req,
    output dll_update_iorst_ack
  );

  modport slave (
    input  dll_update_req_rst_ctrl,
    output dll_update_ack_rst_ctrl,
    output dll_update_iorst_req,
    input  dll_update_iorst_ack
  );
endinterface

`default_nettype wire

// File: rtl/ddrphy_dll_update_ctrl.sv
// ---------------------------------------------------------------------------
// ddrphy_dll_update_ctrl
//   Services the reset controller's DLL update request by freezing the DLL
//   output, pulsing the active-low code update strobe, letting the DLL settle,
//   and then acknowledging with a 4-phase handshake. Optionally re-runs the
//   same sequence periodically; after each periodic update it requests an IO
//   reset from the reset controller and waits for that handshake to finish.
//
//   Build option:
//     DDRPHY_DLL_PERIODIC_UPDATE_EN  defined: period timer, init_done, the
//       periodic source and the IO-reset handshake states are present.
//       Undefined: only the request/acknowledge handshake operates;
//       dll_update_iorst_req and o_iorst_timeout_err are tied low.
//
//   Ports:
//     clk                  clock
//     top_rst_n            asynchronous active-low reset
//     hs_if                slave side of the reset-controller handshake
//     i_dll_lock           DLL lock (asynchronous, synchronised here)
//     o_dll_freeze         DLL output freeze
//     o_dll_update_n       DLL code update strobe, active-low
//     o_update_busy        high whenever the FSM is not idle
//     o_iorst_timeout_err  sticky IO-reset handshake timeout flag
// ---------------------------------------------------------------------------
`default_nettype none

module ddrphy_dll_update_ctrl #(
  parameter int unsigned FREEZE_CYC  = 4,
  parameter int unsigned UPDATE_CYC  = 2,
  parameter int unsigned SETTLE_CYC  = 8,
  parameter int unsigned PERIOD_CYC  = 4096,
  parameter int unsigned ACK_TIMEOUT = 1024
) (
  input  wire logic                      clk,
  input  wire logic                      top_rst_n,
  ddrphy_dll_update_ctrl_if.slave        hs_if,
  input  wire logic                      i_dll_lock,
  output logic                           o_dll_freeze,
  output logic                           o_dll_update_n,
  output logic                           o_update_busy,
  output logic                           o_iorst_timeout_err
);

  // State encoding
  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_FREEZE     = 3'd1;
  localparam logic [2:0] S_UPDATE     = 3'd2;
  localparam logic [2:0] S_SETTLE     = 3'd3;
  localparam logic [2:0] S_ACK        = 3'd4;
`ifdef DDRPHY_DLL_PERIODIC_UPDATE_EN
  localparam logic [2:0] S_IORST_REQ  = 3'd5;
  localparam logic [2:0] S_IORST_WAIT = 3'd6;
`endif

  // Last phase-counter value of each timed state
  localparam logic [7:0] LP_FREEZE_LAST = 8'(FREEZE_CYC - 1);
  localparam logic [7:0] LP_UPDATE_LAST = 8'(UPDATE_CYC - 1);
  localparam logic [7:0] LP_SETTLE_LAST = 8'(SETTLE_CYC - 1);

  // Input synchronisers
  logic r_req_meta;
  logic r_req_s;

  // FSM and phase counter
  logic [2:0] r_state;
  logic [2:0] w_state_nxt;
  logic [7:0] r_phase_cnt;

  // Registered outputs
  logic r_freeze;
  logic r_update_n;
  logic r_ack;
  logic r_busy;

`ifdef DDRPHY_DLL_PERIODIC_UPDATE_EN
  localparam int unsigned       TO_W           = $clog2(ACK_TIMEOUT);
  localparam logic [TO_W-1:0]   LP_TO_LAST     = TO_W'(ACK_TIMEOUT - 1);
  localparam logic [15:0]       LP_PERIOD_LAST = 16'(PERIOD_CYC - 1);

  logic            r_lock_meta;
  logic            r_lock_s;
  logic            r_iack_meta;
  logic            r_iack_s;
  logic [15:0]     r_period_cnt;
  logic [TO_W-1:0] r_to_cnt;
  logic            r_init_done;
  logic            r_src_per;   // 1: current sequence came from the period timer
  logic            r_iorst_req;
  logic            r_err;
  logic            w_period_exp;
  logic            w_to_expire;
`else
  logic            w_unused_cfg;
`endif

  // -------------------------------------------------------------------------
  // Synchronisers
  // -------------------------------------------------------------------------
  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the 2-flop chain into one.
  always_ff @(posedge clk or negedge top_rst_n) begin
    if (!top_rst_n) begin
      r_req_meta <= 1'b0;
      r_req_s    <= 1'b0;
    end else begin
      r_req_meta <= hs_if.dll_update_req_rst_ctrl;
      r_req_s    <= r_req_meta;
    end
  end

`ifdef DDRPHY_DLL_PERIODIC_UPDATE_EN
  always_ff @(posedge clk or negedge top_rst_n) begin
    if (!top_rst_n) begin
      r_lock_meta <= 1'b0;
      r_lock_s    <= 1'b0;
      r_iack_meta <= 1'b0;
      r_iack_s    <= 1'b0;
    end else begin
      r_lock_meta <= i_dll_lock;
      r_lock_s    <= r_lock_meta;
      r_iack_meta <= hs_if.dll_update_iorst_ack;
      r_iack_s    <= r_iack_meta;
    end
  end

  // Periodic updates are held off until the reset controller's own update
  // has completed once, so no IO reset is requested mid PHY bring-up.
  assign w_period_exp = r_init_done && r_lock_s && (r_period_cnt == LP_PERIOD_LAST);
`endif

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    w_state_nxt = r_state;
`ifdef DDRPHY_DLL_PERIODIC_UPDATE_EN
    w_to_expire = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (r_req_s) begin
          w_state_nxt = S_FREEZE;
`ifdef DDRPHY_DLL_PERIODIC_UPDATE_EN
        end else if (w_period_exp) begin
          w_state_nxt = S_FREEZE;
`endif
        end
      end
      S_FREEZE: if (r_phase_cnt == LP_FREEZE_LAST) w_state_nxt = S_UPDATE;
      S_UPDATE: if (r_phase_cnt == LP_UPDATE_LAST) w_state_nxt = S_SETTLE;
      S_SETTLE: begin
        if (r_phase_cnt == LP_SETTLE_LAST) begin
`ifdef DDRPHY_DLL_PERIODIC_UPDATE_EN
          w_state_nxt = r_src_per ? S_IORST_REQ : S_ACK;
`else
          w_state_nxt = S_ACK;
`endif
        end
      end
      // A request already withdrawn still gets a one-cycle acknowledge.
      S_ACK: if (!r_req_s) w_state_nxt = S_IDLE;
`ifdef DDRPHY_DLL_PERIODIC_UPDATE_EN
      S_IORST_REQ: begin
        if (r_iack_s) begin
          w_state_nxt = S_IORST_WAIT;
        end else if (r_to_cnt == LP_TO_LAST) begin
          w_state_nxt = S_IDLE;
          w_to_expire = 1'b1;
        end
      end
      S_IORST_WAIT: begin
        if (!r_iack_s) begin
          w_state_nxt = S_IDLE;
        end else if (r_to_cnt == LP_TO_LAST) begin
          w_state_nxt = S_IDLE;
          w_to_expire = 1'b1;
        end
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // State, phase counter and Moore outputs (decoded from the next state so
  // outputs change on the same edge as the state register)
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge top_rst_n) begin
    if (!top_rst_n) begin
      r_state     <= S_IDLE;
      r_phase_cnt <= 8'd0;
      r_freeze    <= 1'b0;
      r_update_n  <= 1'b1;
      r_ack       <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;

      if (w_state_nxt != r_state)
        r_phase_cnt <= 8'd0;
      else if (r_state == S_FREEZE || r_state == S_UPDATE || r_state == S_SETTLE)
        r_phase_cnt <= r_phase_cnt + 8'd1;
      else
        r_phase_cnt <= 8'd0;

      r_freeze   <= (w_state_nxt == S_FREEZE) || (w_state_nxt == S_UPDATE) ||
                    (w_state_nxt == S_SETTLE);
      r_update_n <= (w_state_nxt != S_UPDATE);
      r_ack      <= (w_state_nxt == S_ACK);
      r_busy     <= (w_state_nxt != S_IDLE);
    end
  end

`ifdef DDRPHY_DLL_PERIODIC_UPDATE_EN
  always_ff @(posedge clk or negedge top_rst_n) begin
    if (!top_rst_n) begin
      r_period_cnt <= 16'd0;
      r_to_cnt     <= '0;
      r_init_done  <= 1'b0;
      r_src_per    <= 1'b0;
      r_iorst_req  <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      // Timer runs only while idle with a locked DLL; leaving idle reloads it.
      if (r_state != S_IDLE || w_state_nxt != S_IDLE || !r_lock_s || !r_init_done)
        r_period_cnt <= 16'd0;
      else
        r_period_cnt <= r_period_cnt + 16'd1;

      if (w_state_nxt != r_state)
        r_to_cnt <= '0;
      else if (r_state == S_IORST_REQ || r_state == S_IORST_WAIT)
        r_to_cnt <= r_to_cnt + 1'b1;

      if (r_state == S_ACK && w_state_nxt == S_IDLE)
        r_init_done <= 1'b1;

      // The request has priority when both sources fire in the same cycle.
      if (r_state == S_IDLE && w_state_nxt == S_FREEZE)
        r_src_per <= !r_req_s;

      r_iorst_req <= (w_state_nxt == S_IORST_REQ);
      r_err       <= r_err | w_to_expire;
    end
  end

  assign hs_if.dll_update_iorst_req = r_iorst_req;
  assign o_iorst_timeout_err        = r_err;
`else
  assign hs_if.dll_update_iorst_req = 1'b0;
  assign o_iorst_timeout_err        = 1'b0;
  assign w_unused_cfg = i_dll_lock ^ hs_if.dll_update_iorst_ack ^
                        (PERIOD_CYC > 0) ^ (ACK_TIMEOUT > 0);
`endif

  assign hs_if.dll_update_ack_rst_ctrl = r_ack;
  assign o_dll_freeze                  = r_freeze;
  assign o_dll_update_n                = r_update_n;
  assign o_update_busy                 = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_ddrphy_dll_update_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ddrphy_dll_update_ctrl
//   Directed bench for ddrphy_dll_update_ctrl. Cycle c counts rising edges
//   after the stimulus change; outputs are sampled 1 ns after each edge and
//   compared as the vector {freeze, update_n, ack, iorst_req, busy, err}.
//   Periodic-build scenarios run when DDRPHY_DLL_PERIODIC_UPDATE_EN is set.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_ddrphy_dll_update_ctrl;

`ifdef DDRPHY_DLL_PERIODIC_UPDATE_EN
  localparam bit PER_EN = 1'b1;
`else
  localparam bit PER_EN = 1'b0;
`endif

  logic clk;
  logic top_rst_n;
  logic i_dll_lock;
  logic o_dll_freeze;
  logic o_dll_update_n;
  logic o_update_busy;
  logic o_iorst_timeout_err;

  int n_checks = 0;
  int n_fail   = 0;

  ddrphy_dll_update_ctrl_if hs_if ();

  ddrphy_dll_update_ctrl #(
    .FREEZE_CYC  (4),
    .UPDATE_CYC  (2),
    .SETTLE_CYC  (8),
    .PERIOD_CYC  (16),
    .ACK_TIMEOUT (8)
  ) u_dut (
    .clk                 (clk),
    .top_rst_n           (top_rst_n),
    .hs_if               (hs_if),
    .i_dll_lock          (i_dll_lock),
    .o_dll_freeze        (o_dll_freeze),
    .o_dll_update_n      (o_dll_update_n),
    .o_update_busy       (o_update_busy),
    .o_iorst_timeout_err (o_iorst_timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [5:0] exp);
    check(tag, {26'd0, o_dll_freeze, o_dll_update_n, hs_if.dll_update_ack_rst_ctrl,
                hs_if.dll_update_iorst_req, o_update_busy, o_iorst_timeout_err},
          {26'd0, exp});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Request raised at c=0 and dropped after edge drop_at. Freeze 3..16,
  // update_n low 7..8, ack from 17 until two edges after req falls (min 1).
  task automatic hs_seq(input string tag, input int drop_at, input bit exp_err);
    int ack_end;
    ack_end = (drop_at + 2 > 17) ? drop_at + 2 : 17;
    hs_if.dll_update_req_rst_ctrl = 1'b1;
    for (int c = 1; c <= ack_end + 3; c++) begin
      tick();
      check_outs($sformatf("%s c%0d", tag, c),
                 {(c >= 3 && c <= 16), !(c >= 7 && c <= 8), (c >= 17 && c <= ack_end),
                  1'b0, (c >= 3 && c <= ack_end), exp_err});
      if (c == drop_at) hs_if.dll_update_req_rst_ctrl = 1'b0;
    end
  endtask

  initial begin
    top_rst_n                      = 1'b0;
    i_dll_lock                     = 1'b0;
    hs_if.dll_update_req_rst_ctrl  = 1'b0;
    hs_if.dll_update_iorst_ack     = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_outs("reset", 6'b010000);
    top_rst_n = 1'b1;
    tick();
    check_outs("post_reset", 6'b010000);

    // Full 4-phase handshake, then a short pulse that drops before the ack.
    hs_seq("hs_basic", 20, 1'b0);
    hs_seq("hs_pulse", 5, 1'b0);

    // DLL unlocked: nothing periodic may start even after init is done.
    for (int c = 1; c <= 40; c++) begin
      tick();
      check_outs($sformatf("nolock_idle c%0d", c), 6'b010000);
    end
    hs_seq("hs_nolock", 20, 1'b0);

`ifdef DDRPHY_DLL_PERIODIC_UPDATE_EN
    // Lock at c=0 -> lock_s at c=2 -> timer hits 15 at c=17 -> freeze at 18.
    // First update: iorst_req 32..38 (ack raised after c=36, dropped after 41),
    // idle from 44, next update at 60; its ack never comes -> timeout at 82.
    i_dll_lock = 1'b1;
    for (int c = 1; c <= 84; c++) begin
      tick();
      check_outs($sformatf("periodic c%0d", c),
                 {((c >= 18 && c <= 31) || (c >= 60 && c <= 73)),
                  !((c >= 22 && c <= 23) || (c >= 64 && c <= 65)),
                  1'b0,
                  ((c >= 32 && c <= 38) || (c >= 74 && c <= 81)),
                  ((c >= 18 && c <= 43) || (c >= 60 && c <= 81)),
                  (c >= 82)});
      if (c == 36) hs_if.dll_update_iorst_ack = 1'b1;
      if (c == 41) hs_if.dll_update_iorst_ack = 1'b0;
      if (c == 82) i_dll_lock = 1'b0;
    end
    // Sticky error survives, HS handshake still serviced.
    hs_seq("hs_after_err", 20, 1'b1);
`else
    // Without the periodic build a locked DLL must never trigger an update.
    i_dll_lock = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      check_outs($sformatf("no_periodic c%0d", c), 6'b010000);
    end
    i_dll_lock = 1'b0;
`endif

    // Reset asserted while update_n is low: outputs return at once.
    hs_if.dll_update_req_rst_ctrl = 1'b1;
    for (int c = 1; c <= 7; c++) tick();
    check_outs("in_update", {5'b10001, PER_EN});
    top_rst_n                     = 1'b0;
    hs_if.dll_update_req_rst_ctrl = 1'b0;
    #1;
    check_outs("async_reset", 6'b010000);
    tick();
    top_rst_n = 1'b1;
    for (int c = 1; c <= 25; c++) begin
      tick();
      check_outs($sformatf("after_reset c%0d", c), 6'b010000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
